// File: rtl/vram_arbiter.sv
// vram_arbiter: time-slices the single-port VRAM between raster fetch and CPU.
// Video owns any slot it requests; the CPU takes the remaining slots and is
// stalled through cpuWait_n until its access completes. Multi-bank CPU writes
// are expanded into one bank write per free slot, lowest bank first.
//
// Ports:
//   clock, reset        system clock, synchronous active-low reset
//   ce                  slot strobe (pixel clock enable)
//   vReq/vBank/vAddr    video fetch request; vData read result
//   cpuReq/cpuWr/cpuMask/cpuBank/cpuAddr/cpuDi   CPU request fields
//   cpuDo, cpuWait_n    CPU read data and stall (low = stall)
//   memA/memWe/memDi    VRAM address {bank, addr}, write strobe, write data
//   memDo               VRAM read data, valid the clock after memA
module vram_arbiter #(
   parameter int unsigned AW = 13,
   parameter int unsigned NB = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ce,
   input  logic          vReq,
   input  logic [1:0]    vBank,
   input  logic [AW-1:0] vAddr,
   output logic [7:0]    vData,
   input  logic          cpuReq,
   input  logic          cpuWr,
   input  logic [NB-1:0] cpuMask,
   input  logic [1:0]    cpuBank,
   input  logic [AW-1:0] cpuAddr,
   input  logic [7:0]    cpuDi,
   output logic [7:0]    cpuDo,
   output logic          cpuWait_n,
   output logic [AW+1:0] memA,
   output logic          memWe,
   output logic [7:0]    memDi,
   input  logic [7:0]    memDo
);

   localparam int unsigned BW = 2;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t        state, nextState;
   logic [NB-1:0] wrMask;
   logic [AW-1:0] wrAddr;
   logic [7:0]    wrData;
   logic          vCapture;
   logic          cpuCapture;

   logic          vSlot, rdSlot, wrSlot;
   logic [BW-1:0] lowBank;
   logic [NB-1:0] remMask;

   // State register
   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (cpuReq) begin
            if (!cpuWr)             nextState = RD;
            else if (cpuMask != '0) nextState = WR;
            else                    nextState = DONE;
         end
         RD:   if (cpuCapture) nextState = DONE;
         WR:   if (wrSlot && remMask == '0) nextState = DONE;
         DONE: if (!cpuReq) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Slot ownership, pending-bank selection and stall
   always_comb begin
      vSlot   = ce & vReq;
      // cpuCapture marks the read already issued; ce cannot recur before DONE
      rdSlot  = ce & ~vReq & (state == RD) & ~cpuCapture;
      wrSlot  = ce & ~vReq & (state == WR);
      lowBank = '0;
      for (int i = int'(NB) - 1; i >= 0; i--) begin
         if (wrMask[i]) lowBank = BW'(i);
      end
      remMask   = wrMask & ~(NB'(1) << lowBank);
      cpuWait_n = ~(((state == IDLE) & cpuReq) | (state == RD) | (state == WR));
   end

   // Memory port and data capture
   always_ff @(posedge clock) begin
      if (!reset) begin
         vData      <= '0;
         cpuDo      <= '0;
         memA       <= '0;
         memWe      <= 1'b0;
         memDi      <= '0;
         wrMask     <= '0;
         wrAddr     <= '0;
         wrData     <= '0;
         vCapture   <= 1'b0;
         cpuCapture <= 1'b0;
      end else begin
         memWe      <= 1'b0;
         vCapture   <= vSlot;
         cpuCapture <= rdSlot;
         if (vCapture)   vData <= memDo;
         if (cpuCapture) cpuDo <= memDo;

         if (vSlot) begin
            memA <= {vBank, vAddr};
         end else if (rdSlot) begin
            memA <= {cpuBank, cpuAddr};
         end else if (wrSlot) begin
            memA   <= {lowBank, wrAddr};
            memDi  <= wrData;
            memWe  <= 1'b1;
            wrMask <= remMask;
         end

         // Write fields are frozen at acceptance
         if (state == IDLE && cpuReq && cpuWr) begin
            wrMask <= cpuMask;
            wrAddr <= cpuAddr;
            wrData <= cpuDi;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a pattern-ROM memory model and a
// write logger.
module tb_vram_arbiter;

   localparam int unsigned AW = 13;
   localparam int unsigned NB = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          ce;
   logic          vReq;
   logic [1:0]    vBank;
   logic [AW-1:0] vAddr;
   logic [7:0]    vData;
   logic          cpuReq;
   logic          cpuWr;
   logic [NB-1:0] cpuMask;
   logic [1:0]    cpuBank;
   logic [AW-1:0] cpuAddr;
   logic [7:0]    cpuDi;
   logic [7:0]    cpuDo;
   logic          cpuWait_n;
   logic [AW+1:0] memA;
   logic          memWe;
   logic [7:0]    memDi;
   logic [7:0]    memDo;

   int tests = 0;
   int fails = 0;

   int            weCnt  = 0;
   int            weNoCe = 0;
   logic          prevCe = 1'b0;
   logic [AW+1:0] weAddr [0:255];
   logic [7:0]    weData [0:255];

   vram_arbiter #(.AW(AW), .NB(NB)) dut (
      .clock(clock), .reset(reset), .ce(ce),
      .vReq(vReq), .vBank(vBank), .vAddr(vAddr), .vData(vData),
      .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuMask(cpuMask), .cpuBank(cpuBank),
      .cpuAddr(cpuAddr), .cpuDi(cpuDi), .cpuDo(cpuDo), .cpuWait_n(cpuWait_n),
      .memA(memA), .memWe(memWe), .memDi(memDi), .memDo(memDo)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] pattern(input logic [AW+1:0] a);
      if (a == 15'h4155) return 8'hA5;
      return a[7:0] ^ {1'b0, a[14:8]};
   endfunction

   // Asynchronous-read memory: data follows memA within the same clock
   assign memDo = pattern(memA);

   always @(posedge clock) begin
      if (memWe) begin
         if (weCnt < 256) begin
            weAddr[weCnt] <= memA;
            weData[weCnt] <= memDi;
         end
         weCnt <= weCnt + 1;
         if (!prevCe) weNoCe <= weNoCe + 1;
      end
      prevCe <= ce;
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // One ce pulse followed by one quiet clock
   task automatic slot(input logic v);
      vReq = v;
      ce   = 1'b1;
      tick();
      ce   = 1'b0;
      vReq = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) tick();
      tests++; if (vData !== 8'h00) begin fails++; $display("FAIL reset_vData got %h want 00", vData); end
      tests++; if (cpuDo !== 8'h00) begin fails++; $display("FAIL reset_cpuDo got %h want 00", cpuDo); end
      tests++; if (memWe !== 1'b0) begin fails++; $display("FAIL reset_memWe got %b want 0", memWe); end
      tests++; if (memA !== 15'h0000) begin fails++; $display("FAIL reset_memA got %h want 0000", memA); end
      tests++; if (memDi !== 8'h00) begin fails++; $display("FAIL reset_memDi got %h want 00", memDi); end
      tests++; if (cpuWait_n !== 1'b1) begin fails++; $display("FAIL reset_wait got %b want 1", cpuWait_n); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_read;
      cpuReq = 1'b1; cpuWr = 1'b0; cpuBank = 2'd2; cpuAddr = 13'h0155;
      #1;
      tests++; if (cpuWait_n !== 1'b0) begin fails++; $display("FAIL read_wait_drop got %b want 0", cpuWait_n); end
      tick(); tick();
      tests++; if (cpuWait_n !== 1'b0) begin fails++; $display("FAIL read_wait_pre got %b want 0", cpuWait_n); end
      ce = 1'b1;
      tick();
      ce = 1'b0;
      tests++; if (memA !== 15'h4155) begin fails++; $display("FAIL read_memA got %h want 4155", memA); end
      tests++; if (cpuWait_n !== 1'b0) begin fails++; $display("FAIL read_wait_slot got %b want 0", cpuWait_n); end
      tick();
      tests++; if (cpuDo !== 8'hA5) begin fails++; $display("FAIL read_cpuDo got %h want a5", cpuDo); end
      tests++; if (cpuWait_n !== 1'b1) begin fails++; $display("FAIL read_wait_rise got %b want 1", cpuWait_n); end
      cpuReq = 1'b0;
      tick();
   endtask

   task automatic test_write_interleave;
      int base;
      logic vPat [0:4];
      vPat[0] = 1'b1; vPat[1] = 1'b0; vPat[2] = 1'b1; vPat[3] = 1'b0; vPat[4] = 1'b0;
      base = weCnt;
      vBank = 2'd2; vAddr = 13'h0010;
      cpuReq = 1'b1; cpuWr = 1'b1; cpuMask = 4'b1011; cpuAddr = 13'h1FFF; cpuDi = 8'h3C;
      tick();
      cpuDi = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         slot(vPat[i]);
         if (i == 0) begin
            tests++; if (vData !== 8'h50) begin fails++; $display("FAIL wr_vData got %h want 50", vData); end
            tests++; if (weCnt - base !== 0) begin fails++; $display("FAIL wr_video_slot_writes got %0d want 0", weCnt - base); end
         end
         if (i == 3) begin
            tests++; if (cpuWait_n !== 1'b0) begin fails++; $display("FAIL wr_wait_mid got %b want 0", cpuWait_n); end
            tests++; if (weCnt - base !== 2) begin fails++; $display("FAIL wr_count_mid got %0d want 2", weCnt - base); end
         end
      end
      tests++; if (cpuWait_n !== 1'b1) begin fails++; $display("FAIL wr_wait_end got %b want 1", cpuWait_n); end
      tests++; if (weCnt - base !== 3) begin fails++; $display("FAIL wr_count got %0d want 3", weCnt - base); end
      tests++; if (weAddr[base] !== 15'h1FFF) begin fails++; $display("FAIL wr_addr0 got %h want 1fff", weAddr[base]); end
      tests++; if (weAddr[base+1] !== 15'h3FFF) begin fails++; $display("FAIL wr_addr1 got %h want 3fff", weAddr[base+1]); end
      tests++; if (weAddr[base+2] !== 15'h7FFF) begin fails++; $display("FAIL wr_addr2 got %h want 7fff", weAddr[base+2]); end
      for (int i = 0; i < 3; i++) begin
         tests++; if (weData[base+i] !== 8'h3C) begin fails++; $display("FAIL wr_data%0d got %h want 3c", i, weData[base+i]); end
      end
      cpuReq = 1'b0;
      tick();
   endtask

   task automatic test_starve;
      logic [AW+1:0] a;
      cpuReq = 1'b1; cpuWr = 1'b0; cpuBank = 2'd1; cpuAddr = 13'h0033;
      vBank = 2'd3;
      for (int i = 0; i < 40; i++) begin
         vAddr = AW'(i);
         a = {2'd3, AW'(i)};
         slot(1'b1);
         tests++; if (memA !== a) begin fails++; $display("FAIL starve_memA%0d got %h want %h", i, memA, a); end
         tests++; if (vData !== (8'(i) ^ 8'h60)) begin fails++; $display("FAIL starve_vData%0d got %h want %h", i, vData, 8'(i) ^ 8'h60); end
         tests++; if (cpuWait_n !== 1'b0) begin fails++; $display("FAIL starve_wait%0d got %b want 0", i, cpuWait_n); end
      end
      slot(1'b0);
      tests++; if (cpuDo !== 8'h13) begin fails++; $display("FAIL starve_cpuDo got %h want 13", cpuDo); end
      tests++; if (cpuWait_n !== 1'b1) begin fails++; $display("FAIL starve_wait_end got %b want 1", cpuWait_n); end
      cpuReq = 1'b0;
      tick();
   endtask

   task automatic test_mask_zero;
      int base;
      base = weCnt;
      cpuReq = 1'b1; cpuWr = 1'b1; cpuMask = 4'b0000; cpuAddr = 13'h0123; cpuDi = 8'h5A;
      #1;
      tests++; if (cpuWait_n !== 1'b0) begin fails++; $display("FAIL mask0_wait_drop got %b want 0", cpuWait_n); end
      tick();
      tests++; if (cpuWait_n !== 1'b1) begin fails++; $display("FAIL mask0_wait_rise got %b want 1", cpuWait_n); end
      slot(1'b0); slot(1'b0);
      tests++; if (weCnt - base !== 0) begin fails++; $display("FAIL mask0_writes got %0d want 0", weCnt - base); end
      cpuReq = 1'b0;
      tick();
   endtask

   task automatic test_hold_done;
      int base;
      base = weCnt;
      cpuReq = 1'b1; cpuWr = 1'b1; cpuMask = 4'b0100; cpuAddr = 13'h0005; cpuDi = 8'h99;
      tick();
      slot(1'b0);
      repeat (5) slot(1'b0);
      tests++; if (weCnt - base !== 1) begin fails++; $display("FAIL hold_writes got %0d want 1", weCnt - base); end
      tests++; if (cpuWait_n !== 1'b1) begin fails++; $display("FAIL hold_wait got %b want 1", cpuWait_n); end
      cpuReq = 1'b0;
      tick();
      cpuReq = 1'b1;
      tick();
      slot(1'b0);
      tests++; if (weCnt - base !== 2) begin fails++; $display("FAIL hold_rereq_writes got %0d want 2", weCnt - base); end
      tests++; if (weAddr[base+1] !== 15'h4005) begin fails++; $display("FAIL hold_addr got %h want 4005", weAddr[base+1]); end
      tests++; if (weData[base+1] !== 8'h99) begin fails++; $display("FAIL hold_data got %h want 99", weData[base+1]); end
      cpuReq = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_write;
      int base;
      base = weCnt;
      cpuReq = 1'b1; cpuWr = 1'b1; cpuMask = 4'b1111; cpuAddr = 13'h0AAA; cpuDi = 8'h77;
      tick();
      slot(1'b0); slot(1'b0);
      tests++; if (weCnt - base !== 2) begin fails++; $display("FAIL rstwr_pre_writes got %0d want 2", weCnt - base); end
      cpuReq = 1'b0;
      reset  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ce = (i == 1);
         tick();
         tests++; if (memWe !== 1'b0) begin fails++; $display("FAIL rstwr_memWe%0d got %b want 0", i, memWe); end
      end
      ce = 1'b0;
      reset = 1'b1;
      tests++; if (cpuWait_n !== 1'b1) begin fails++; $display("FAIL rstwr_wait got %b want 1", cpuWait_n); end
      tests++; if (memDi !== 8'h00) begin fails++; $display("FAIL rstwr_memDi got %h want 00", memDi); end
      repeat (4) slot(1'b0);
      tests++; if (weCnt - base !== 2) begin fails++; $display("FAIL rstwr_post_writes got %0d want 2", weCnt - base); end
      tests++; if (memA !== 15'h0000) begin fails++; $display("FAIL rstwr_memA got %h want 0000", memA); end
   endtask

   initial begin
      reset = 1'b0; ce = 1'b0; vReq = 1'b0; vBank = 2'd0; vAddr = '0;
      cpuReq = 1'b0; cpuWr = 1'b0; cpuMask = '0; cpuBank = 2'd0; cpuAddr = '0; cpuDi = 8'h00;
      test_reset();
      test_read();
      test_write_interleave();
      test_starve();
      test_mask_zero();
      test_hold_done();
      test_reset_mid_write();
      tests++; if (weNoCe !== 0) begin fails++; $display("FAIL we_without_ce got %0d want 0", weNoCe); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
